// File: rtl/pin_pkg.sv
// Shared definitions for the keypad PIN transmitter and the gate controller.
package pin_pkg;

  typedef enum logic [2:0] {
    ESPERA    = 3'b001,
    UN_DIGITO = 3'b010,
    ENVIO     = 3'b100
  } estado_t;

  localparam logic [3:0] TECLA_BORRAR = 4'hA;
  localparam logic [7:0] PIN_VACIO    = 8'h00;
  localparam logic [7:0] PIN_CORRECTO = 8'b00001000;

  function automatic logic es_digito(input logic [3:0] tecla);
    return tecla <= 4'd9;
  endfunction

endpackage

// File: rtl/pin_entrada_detector_flanco.sv
// Rising-edge detector: one press event per low-to-high transition of the input.
module detector_flanco (
  input  logic Clk,
  input  logic Reset,
  input  logic Entrada,
  output logic Flanco
);

  logic previo;

  always_ff @(posedge Clk) begin
    if (Reset) previo <= 1'b0;
    else       previo <= Entrada;
  end

  assign Flanco = Entrada & ~previo;

endmodule

// File: rtl/pin_entrada.sv
// Assembles two BCD key presses into a one-cycle 8-bit PIN code for the gate controller.
module pin_entrada
  import pin_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 10
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Habilitar,
  input  logic       Tecla_valida,
  input  logic [3:0] Tecla,
  output logic [7:0] Pin,
  output logic       Enviado,
  output logic       Digito_pend,
  output logic       Error
);

  estado_t           estado, estado_sig;
  logic [CNT_W-1:0]  cnt, cnt_sig;
  logic [3:0]        digito, digito_sig;
  logic [7:0]        pin_sig;
  logic              enviado_sig, error_sig;
  logic              pulso;

  detector_flanco u_flanco (
    .Clk     (Clk),
    .Reset   (Reset),
    .Entrada (Tecla_valida),
    .Flanco  (pulso)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado      <= ESPERA;
      cnt         <= '0;
      digito      <= 4'd0;
      Pin         <= PIN_VACIO;
      Enviado     <= 1'b0;
      Digito_pend <= 1'b0;
      Error       <= 1'b0;
    end else begin
      estado      <= estado_sig;
      cnt         <= cnt_sig;
      digito      <= digito_sig;
      Pin         <= pin_sig;
      Enviado     <= enviado_sig;
      Digito_pend <= (estado_sig == UN_DIGITO);
      Error       <= error_sig;
    end
  end

  always_comb begin
    estado_sig  = estado;
    cnt_sig     = cnt;
    digito_sig  = digito;
    pin_sig     = PIN_VACIO;
    enviado_sig = 1'b0;
    error_sig   = 1'b0;
    case (estado)
      ESPERA: begin
        if (pulso && Habilitar && es_digito(Tecla)) begin
          estado_sig = UN_DIGITO;
          digito_sig = Tecla;
          cnt_sig    = '0;
        end
      end
      UN_DIGITO: begin
        // Losing enable beats any key event; a digit beats a same-cycle timeout.
        if (!Habilitar) begin
          estado_sig = ESPERA;
        end else if (pulso && es_digito(Tecla)) begin
          if (digito == 4'd0 && Tecla == 4'd0) begin
            error_sig  = 1'b1;
            estado_sig = ESPERA;
          end else begin
            pin_sig     = {digito, Tecla};
            enviado_sig = 1'b1;
            estado_sig  = ENVIO;
          end
        end else if (pulso && Tecla == TECLA_BORRAR) begin
          estado_sig = ESPERA;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          error_sig  = 1'b1;
          estado_sig = ESPERA;
        end else begin
          cnt_sig = cnt + 1'b1;
        end
      end
      ENVIO:   estado_sig = ESPERA;
      default: estado_sig = ESPERA;
    endcase
  end

endmodule

// File: tb/tb_pin_entrada.sv
// Randomized and directed scoreboard bench for pin_entrada with a short timeout.
module tb_pin_entrada;

  localparam int T = 8;

  logic       Clk = 1'b0;
  logic       Reset, Habilitar, Tecla_valida;
  logic [3:0] Tecla;
  logic [7:0] Pin;
  logic       Enviado, Digito_pend, Error;

  pin_entrada #(.TIMEOUT(T), .CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset), .Habilitar(Habilitar), .Tecla_valida(Tecla_valida),
    .Tecla(Tecla), .Pin(Pin), .Enviado(Enviado), .Digito_pend(Digito_pend), .Error(Error)
  );

  always #5 Clk = ~Clk;

  typedef struct { bit is_err; logic [7:0] pin; } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0;

  // Reference: an entry is a pending first digit plus its age; sending blanks one edge.
  bit       m_prev = 0, m_have = 0, m_blank = 0;
  int       m_age = 0;
  int       m_d1 = 0;

  task automatic step(input bit rst, input bit hab, input bit tv, input int key);
    bit   ev;
    exp_t e;
    Reset = rst; Habilitar = hab; Tecla_valida = tv; Tecla = 4'(key);
    if (rst) begin
      m_prev = 0; m_have = 0; m_blank = 0;
    end else begin
      ev = tv && !m_prev;
      m_prev = tv;
      if (m_blank) m_blank = 0;
      else if (!m_have) begin
        if (ev && hab && key <= 9) begin m_have = 1; m_d1 = key; m_age = 0; end
      end else if (!hab) m_have = 0;
      else if (ev && key <= 9) begin
        m_have = 0;
        if (m_d1 == 0 && key == 0) begin e.is_err = 1; e.pin = 8'h00; end
        else begin e.is_err = 0; e.pin = 8'(m_d1 * 16 + key); m_blank = 1; end
        q.push_back(e);
      end else if (ev && key == 10) m_have = 0;
      else if (m_age + 1 >= T) begin
        m_have = 0; e.is_err = 1; e.pin = 8'h00; q.push_back(e);
      end else m_age++;
    end
    @(posedge Clk); #1;
    tests++;
    if (Digito_pend !== m_have) begin
      fails++;
      $display("FAIL digito_pend t=%0t got %b expected %b", $time, Digito_pend, m_have);
    end
  endtask

  task automatic press(input int key, input int hold, input int gap, input bit hab = 1);
    for (int i = 0; i < hold; i++) step(0, hab, 1, key);
    for (int i = 0; i < gap; i++)  step(0, hab, 0, key);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0);
  endtask

  bit prev_active = 0;
  always @(negedge Clk) begin
    exp_t e;
    if (Enviado || Pin != 8'h00 || Error) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output t=%0t Pin=%h Enviado=%b Error=%b expected none", $time, Pin, Enviado, Error);
      end else begin
        e = q.pop_front();
        if (Error !== e.is_err || Pin !== e.pin || Enviado !== !e.is_err) begin
          fails++;
          $display("FAIL output t=%0t Pin=%h Enviado=%b Error=%b expected Pin=%h Enviado=%b Error=%b",
                   $time, Pin, Enviado, Error, e.pin, !e.is_err, e.is_err);
        end
      end
    end
    if (Pin != 8'h00) begin
      tests++;
      if (prev_active) begin
        fails++;
        $display("FAIL pin_consecutive t=%0t Pin=%h held for more than one cycle", $time, Pin);
      end
    end
    prev_active = (Pin != 8'h00);
  end

  initial begin
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    tests++;
    if (Pin !== 8'h00 || Enviado !== 1'b0 || Error !== 1'b0 || Digito_pend !== 1'b0) begin
      fails++;
      $display("FAIL reset_state Pin=%h Enviado=%b Error=%b Pend=%b expected all zero", Pin, Enviado, Error, Digito_pend);
    end
    // Directed sequences from the test plan.
    press(0, 3, 2); press(8, 1, 3);
    press(1, 1, 2); press(2, 10, 3);
    press(5, 1, 0); idle(T + 3); press(0, 1, 1); press(8, 1, 3);
    press(3, 1, 1); press(10, 1, 1); press(0, 1, 1); press(8, 1, 3);
    press(0, 1, 1); press(0, 1, 3);
    press(7, 1, 1); step(0, 0, 0, 0); press(9, 1, 3, 0); press(9, 1, 3);
    press(7, 1, 1); step(1, 1, 0, 0); press(9, 1, 3); idle(T + 2);
    press(4, 1, 0); idle(T - 3); press(6, 1, 3);
    press(4, 1, 0); idle(T - 2); press(6, 1, 3);
    press(2, 1, 0); press(3, 1, 0); press(4, 1, 3); idle(T + 2);
    // Random traffic.
    begin
      bit tv = 0; int key = 0; bit hab = 1; bit rst;
      for (int i = 0; i < 4000; i++) begin
        if (tv) begin if ($urandom_range(2) == 0) tv = 0; end
        else if ($urandom_range(2) == 0) begin tv = 1; key = $urandom_range(15); if ($urandom_range(3) == 0) key = 0; end
        if ($urandom_range(30) == 0) hab = ~hab;
        rst = ($urandom_range(250) == 0);
        if ($urandom_range(9) == 0 && !tv) begin
          for (int j = 0; j < T + 1; j++) step(0, hab, 0, key);
        end
        step(rst, hab, tv, key);
      end
    end
    idle(4);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL missing_outputs got %0d unmatched expected outputs, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pin_entrada.md
Name: pin_entrada

Overview:
Keypad-side transmitter that drives the 8-bit Pin bus into the gate controller. It edge-detects key presses and assembles two BCD digits into an 8-bit code. Each completed code is presented for exactly one clock cycle, so one entry counts as one attempt. At all other times Pin is held at 8'h00, which the controller treats as "no entry".

Parameters:
TIMEOUT, 1000, cycles allowed between first and second digit before the partial entry is discarded (must be >= 2).
CNT_W, 10, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT.

Ports:
Clk  input  1  system clock, all logic on rising edge.
Reset  input  1  synchronous, active-high reset.
Habilitar  input  1  entry enabled (driven from Vehiculo or Bloqueo); low aborts a partial entry.
Tecla_valida  input  1  level, high while a key is held; one press = one rising edge.
Tecla  input  4  key code, stable while Tecla_valida high; 0-9 digit, 4'hA borrar, 4'hB-4'hF ignored.
Pin  output  8  {first_digit, second_digit} BCD for one cycle, else 8'h00.
Enviado  output  1  pulse, high the same cycle Pin is non-zero.
Digito_pend  output  1  high while one digit is stored.
Error  output  1  one-cycle pulse on timeout or on rejected code "00".

Behaviour:
- One clock (Clk); reset is synchronous and active-high (Reset). Reset forces state ESPERA, Pin=8'h00, Enviado=0, Digito_pend=0, Error=0, timeout counter=0, digit register=0, edge-detector history=0.
- Press event: Tecla_valida=1 this edge and 0 at previous edge. A key held for N cycles gives one event.
- All outputs are registered.
- States, one-hot:
  - ESPERA: no digit stored.
    - Digit event with Habilitar=1 -> store digit, go to UN_DIGITO, clear counter.
    - Borrar, ignored codes, or any event with Habilitar=0 -> stay.
  - UN_DIGITO: Digito_pend=1; counter increments every cycle.
    - Digit event -> if both digits are 0, pulse Error next cycle and go to ESPERA. Otherwise load Pin={d1,d2}, assert Enviado, go to ENVIO.
    - Borrar event -> go to ESPERA, no Error.
    - Counter reaches TIMEOUT-1 with no event -> pulse Error, go to ESPERA.
    - Habilitar=0 -> go to ESPERA, no Error. This takes priority over a same-cycle key event.
    - A same-cycle digit event and timeout: the digit wins.
  - ENVIO: lasts exactly one cycle with Pin/Enviado visible, then unconditionally goes to ESPERA with Pin=8'h00.
    - Key events here are discarded, but edge history still updates, so a held key does not re-fire.
    - Habilitar=0 does not cut the pulse short.
- Latency: a second-digit event sampled at edge k gives Pin valid in the cycle after edge k, for one cycle only.
- Pin is never non-zero for more than one consecutive cycle. Two codes are separated by at least one cycle of 8'h00.
- Reset mid-entry, in any state, discards the stored digit with no Error pulse.

Decomposition:
- Shared package pin_pkg:
  - state encodings ESPERA=3'b001, UN_DIGITO=3'b010, ENVIO=3'b100;
  - TECLA_BORRAR=4'hA;
  - PIN_VACIO=8'h00;
  - PIN_CORRECTO=8'b00001000, shared with the controller.
- One sub-module, detector_flanco: 1-bit rising-edge detector with synchronous reset, output press event.

Test Plan:
- Reset, then press 0 (3 cycles held), release, press 8 -> Pin=8'h08 and Enviado=1 for exactly one cycle, then Pin=8'h00; Digito_pend 1 between the presses.
- Press 1 then 2 with Habilitar=1 -> single cycle Pin=8'h12; keep key 2 held 10 cycles -> no further Pin activity.
- Press 5, then wait TIMEOUT cycles (set TIMEOUT=8) -> Error pulses once, Digito_pend drops, Pin stays 8'h00; then 0,8 -> Pin=8'h08.
- Press 3, then 4'hA, then 0, 8 -> no Pin for 3x; Pin=8'h08 once; no Error.
- Press 0, 0 -> Error one cycle, Pin stays 8'h00, state back to ESPERA.
- Press 7, drop Habilitar, then press 9 -> no Pin output. Also: press 7, assert Reset for one cycle, then press 9 -> Digito_pend goes 0 on reset, press 9 only sets Digito_pend, no Pin.
